// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths and bus layout for the register-file write port.
// The RF write bus packs {we, waddr, wdata}, MSB first, like the writeback bus.
package rf_wport_arbiter_pkg;

    localparam int RF_XLEN  = 64;
    localparam int RF_AW    = 5;
    localparam int RF_BUS_W = 1 + RF_AW + RF_XLEN;

    typedef struct packed {
        logic               we;
        logic [RF_AW-1:0]   waddr;
        logic [RF_XLEN-1:0] wdata;
    } rf_wbus_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_FIFO = 2'd2
    } gnt_src_e;

endpackage

// File: rtl/rf_wport_fifo.sv
// In-order holding FIFO for long-latency results.
// Every slot's address and valid bit are exposed so that the hazard query can search the whole FIFO.
module rf_wport_fifo #(
    parameter int AW    = 5,
    parameter int DW    = 64,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic [AW-1:0]       push_addr_i,
    input  logic [DW-1:0]       push_data_i,
    input  logic                pop_i,
    output logic [AW-1:0]       head_addr_o,
    output logic [DW-1:0]       head_data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH*AW-1:0] ent_addr_o,
    output logic [DEPTH-1:0]    ent_vld_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]    wr_ptr_q, rd_ptr_q, count;
    logic [AW-1:0]  addr_q [DEPTH];
    logic [DW-1:0]  data_q [DEPTH];
    logic           push_ok, pop_ok;
    logic [PW-1:0]  off;

    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign head_addr_o = addr_q[rd_ptr_q[PW-1:0]];
    assign head_data_o = data_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[wr_ptr_q[PW-1:0]] <= push_addr_i;
            data_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        end
    end

    always_comb begin
        ent_addr_o = '0;
        ent_vld_o  = '0;
        off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q[PW-1:0];
            ent_vld_o[i] = ({1'b0, off} < count);
            ent_addr_o[i*AW +: AW] = addr_q[i];
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port owner: writeback normally wins, and long-latency results wait in a FIFO.
// A starvation counter forces the FIFO head after STARVE_MAX writeback wins.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int XLEN       = RF_XLEN,
    parameter int AW         = RF_AW,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            wb_ready,
    input  logic            mdu_valid,
    input  logic [AW-1:0]   mdu_waddr,
    input  logic [XLEN-1:0] mdu_wdata,
    output logic            mdu_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [AW-1:0]   qry_addr,
    output logic            qry_hit,
    output logic            starve_force
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [AW-1:0]            head_addr;
    logic [XLEN-1:0]          head_data;
    logic [FIFO_DEPTH*AW-1:0] ent_addr;
    logic [FIFO_DEPTH-1:0]    ent_vld;
    logic [SW-1:0]            starve_q, starve_d;
    logic [AW+XLEN:0]         rf_q, rf_d;
    gnt_src_e                 gnt_src;
    logic [AW-1:0]            gnt_addr;
    logic [XLEN-1:0]          gnt_data;
    logic                     force_head, match;

    rf_wport_fifo #(
        .AW    (AW),
        .DW    (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_addr_i (mdu_waddr),
        .push_data_i (mdu_wdata),
        .pop_i       (fifo_pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .ent_addr_o  (ent_addr),
        .ent_vld_o   (ent_vld)
    );

    assign force_head   = !rst && !fifo_empty && (starve_q == SW'(STARVE_MAX));
    // Neither ready depends on its own valid, so no combinational loop back to the requesters.
    assign wb_ready     = !rst && !force_head;
    assign mdu_ready    = !rst && !fifo_full;
    assign starve_force = force_head;
    assign fifo_push    = mdu_valid && mdu_ready;
    assign fifo_pop     = (gnt_src == GNT_FIFO);

    always_comb begin
        gnt_src  = GNT_NONE;
        gnt_addr = head_addr;
        gnt_data = head_data;
        if (rst) begin
            gnt_src = GNT_NONE;
        end else if (force_head) begin
            gnt_src = GNT_FIFO;
        end else if (wb_valid) begin
            gnt_src  = GNT_WB;
            gnt_addr = wb_waddr;
            gnt_data = wb_wdata;
        end else if (!fifo_empty) begin
            gnt_src = GNT_FIFO;
        end
    end

    always_comb begin
        rf_d           = rf_q;
        rf_d[AW+XLEN]  = 1'b0;
        if (gnt_src != GNT_NONE) rf_d = {gnt_addr != '0, gnt_addr, gnt_data};
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (gnt_src == GNT_WB && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q     <= '0;
            starve_q <= '0;
        end else begin
            rf_q     <= rf_d;
            starve_q <= starve_d;
        end
    end

    assign rf_we    = rf_q[AW+XLEN];
    assign rf_waddr = rf_q[AW+XLEN-1 -: AW];
    assign rf_wdata = rf_q[XLEN-1:0];

    always_comb begin
        match = rf_we && (rf_waddr == qry_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_vld[i] && ent_addr[i*AW +: AW] == qry_addr) match = 1'b1;
        end
    end

    assign qry_hit = !rst && (qry_addr != '0) && match;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomised and directed bench for rf_wport_arbiter against a queue-based model of the port.
module tb_rf_wport_arbiter;
    localparam int XLEN  = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_valid, wb_ready, mdu_valid, mdu_ready;
    logic [AW-1:0]   wb_waddr, mdu_waddr, rf_waddr, qry_addr;
    logic [XLEN-1:0] wb_wdata, mdu_wdata, rf_wdata;
    logic            rf_we, qry_hit, starve_force;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(
        .XLEN(XLEN), .AW(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_ready(wb_ready),
        .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata), .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .qry_addr(qry_addr), .qry_hit(qry_hit), .starve_force(starve_force)
    );

    typedef struct {
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t            mq[$];
    int              m_starve;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [XLEN-1:0] m_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, compare against the model, clock, advance the model.
    task automatic step(input logic r, input logic wv, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                        input logic mv, input logic [AW-1:0] ma, input logic [XLEN-1:0] md,
                        input logic [AW-1:0] qa,
                        output logic o_wbr, output logic o_mdr, output logic o_hit, output logic o_frc);
        logic e_force, e_wbr, e_mdr, e_hit, was_empty;
        int   gsrc;
        logic            n_we;
        logic [AW-1:0]   n_addr;
        logic [XLEN-1:0] n_data;
        ent_t            g;
        int              n_starve;

        rst = r; wb_valid = wv; wb_waddr = wa; wb_wdata = wd;
        mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md; qry_addr = qa;
        #1;
        if (r) begin
            e_force = 0; e_wbr = 0; e_mdr = 0; e_hit = 0; gsrc = 0;
        end else begin
            e_force = (mq.size() > 0) && (m_starve == SMAX);
            e_wbr   = !e_force;
            e_mdr   = (mq.size() < DEPTH);
            e_hit   = 0;
            if (qa != 0) begin
                if (m_we && m_addr == qa) e_hit = 1;
                foreach (mq[i]) if (mq[i].a == qa) e_hit = 1;
            end
            if (e_force)              gsrc = 2;
            else if (wv)              gsrc = 1;
            else if (mq.size() > 0)   gsrc = 2;
            else                      gsrc = 0;
        end
        chk("rf_we", rf_we, m_we);
        chk("rf_waddr", rf_waddr, m_addr);
        chk("rf_wdata", rf_wdata, m_data);
        chk("wb_ready", wb_ready, e_wbr);
        chk("mdu_ready", mdu_ready, e_mdr);
        chk("qry_hit", qry_hit, e_hit);
        chk("starve_force", starve_force, e_force);
        o_wbr = wb_ready; o_mdr = mdu_ready; o_hit = qry_hit; o_frc = starve_force;

        n_we = 0; n_addr = m_addr; n_data = m_data; n_starve = m_starve;
        was_empty = (mq.size() == 0);
        if (!r) begin
            if (gsrc == 1) begin
                n_we = (wa != 0); n_addr = wa; n_data = wd;
            end else if (gsrc == 2) begin
                g = mq[0];
                n_we = (g.a != 0); n_addr = g.a; n_data = g.d;
            end
            if (was_empty || gsrc == 2)         n_starve = 0;
            else if (gsrc == 1 && m_starve < SMAX) n_starve = m_starve + 1;
        end
        @(posedge clk);
        if (r) begin
            mq.delete(); m_starve = 0; m_we = 0; m_addr = '0; m_data = '0;
        end else begin
            m_we = n_we; m_addr = n_addr; m_data = n_data; m_starve = n_starve;
            if (gsrc == 2) void'(mq.pop_front());
            if (mv && e_mdr) mq.push_back('{a: ma, d: md});
        end
        @(negedge clk);
    endtask

    logic     o_wbr, o_mdr, o_hit, o_frc;
    int       ngrants, nwait;
    logic [AW-1:0] order[$];

    initial begin
        rst = 1; wb_valid = 0; wb_waddr = '0; wb_wdata = '0;
        mdu_valid = 0; mdu_waddr = '0; mdu_wdata = '0; qry_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mq.delete(); m_starve = 0; m_we = 0; m_addr = '0; m_data = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0, o_wbr, o_mdr, o_hit, o_frc);
        chk("rst_mdu_ready", o_mdr, 0);
        chk("rst_rf_we", rf_we, 0);

        // Writeback only
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, AW'(k), 64'h11 * k, 0, 0, 0, 0, o_wbr, o_mdr, o_hit, o_frc);
            chk("wbA_ready", o_wbr, 1);
            chk("wbA_we", rf_we, 1);
            chk("wbA_addr", rf_waddr, k);
            chk("wbA_data", rf_wdata, 64'h11 * k);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, o_wbr, o_mdr, o_hit, o_frc);
        chk("wbA_idle_we", rf_we, 0);

        // MDU on an idle port
        step(0, 0, 0, 0, 1, 5, 64'hDEAD, 5, o_wbr, o_mdr, o_hit, o_frc);
        chk("mduB_c1_we", rf_we, 0);
        chk("mduB_c1_hit", qry_hit, 1);
        step(0, 0, 0, 0, 0, 0, 0, 5, o_wbr, o_mdr, o_hit, o_frc);
        chk("mduB_c2_we", rf_we, 1);
        chk("mduB_c2_addr", rf_waddr, 5);
        chk("mduB_c2_data", rf_wdata, 64'hDEAD);
        chk("mduB_c2_hit", qry_hit, 1);
        step(0, 0, 0, 0, 0, 0, 0, 5, o_wbr, o_mdr, o_hit, o_frc);
        chk("mduB_c3_hit", qry_hit, 0);

        // Starvation
        step(0, 1, 7, 64'h77, 1, 6, 64'h66, 0, o_wbr, o_mdr, o_hit, o_frc);
        ngrants = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 7, 64'h700 + i, 0, 0, 0, 0, o_wbr, o_mdr, o_hit, o_frc);
            if (!o_wbr) begin
                chk("starveC_force", o_frc, 1);
                break;
            end
            ngrants++;
        end
        chk("starveC_grants", ngrants, 4);
        chk("starveC_addr", rf_waddr, 6);
        chk("starveC_data", rf_wdata, 64'h66);
        step(0, 1, 7, 64'h7FF, 0, 0, 0, 0, o_wbr, o_mdr, o_hit, o_frc);
        chk("starveC_after_ready", o_wbr, 1);

        // FIFO full with a held third request
        order.delete();
        step(0, 1, 20, 64'h2020, 1, 8, 64'h88, 0, o_wbr, o_mdr, o_hit, o_frc);
        step(0, 1, 20, 64'h2021, 1, 9, 64'h99, 0, o_wbr, o_mdr, o_hit, o_frc);
        nwait = 0;
        for (int i = 0; i < 20; i++) begin
            nwait++;
            step(0, 1, 20, 64'h3000 + i, 1, 10, 64'hAA, 0, o_wbr, o_mdr, o_hit, o_frc);
            if (rf_we && rf_waddr != 20) order.push_back(rf_waddr);
            if (o_mdr) break;
        end
        chk("fullD_wait", nwait, 5);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 20, 64'h4000 + i, 0, 0, 0, 0, o_wbr, o_mdr, o_hit, o_frc);
            if (rf_we && rf_waddr != 20) order.push_back(rf_waddr);
        end
        chk("fullD_count", order.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < order.size()) chk("fullD_order", order[i], 8 + i);
        end

        // x0 writes
        step(0, 1, 0, 64'hFF, 0, 0, 0, 0, o_wbr, o_mdr, o_hit, o_frc);
        chk("x0E_wb_ready", o_wbr, 1);
        chk("x0E_wb_we", rf_we, 0);
        step(0, 0, 0, 0, 1, 0, 64'h1234, 0, o_wbr, o_mdr, o_hit, o_frc);
        step(0, 0, 0, 0, 0, 0, 0, 0, o_wbr, o_mdr, o_hit, o_frc);
        chk("x0E_mdu_we", rf_we, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, o_wbr, o_mdr, o_hit, o_frc);
        chk("x0E_empty_we", rf_we, 0);

        // Reset with two pending entries
        step(0, 1, 21, 64'h21, 1, 11, 64'hB1, 0, o_wbr, o_mdr, o_hit, o_frc);
        step(0, 1, 21, 64'h22, 1, 12, 64'hB2, 11, o_wbr, o_mdr, o_hit, o_frc);
        step(1, 1, 21, 64'h23, 1, 13, 64'hB3, 11, o_wbr, o_mdr, o_hit, o_frc);
        chk("rstF_mdu_ready", o_mdr, 0);
        chk("rstF_hit", o_hit, 0);
        chk("rstF_we", rf_we, 0);
        step(0, 0, 0, 0, 0, 0, 0, 11, o_wbr, o_mdr, o_hit, o_frc);
        chk("rstF_rel_mdu_ready", o_mdr, 1);
        chk("rstF_rel_hit", o_hit, 0);
        chk("rstF_rel_we", rf_we, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), {$urandom, $urandom},
                 $urandom_range(0, 9) < 5, AW'($urandom_range(0, 7)), {$urandom, $urandom},
                 AW'($urandom_range(0, 7)),
                 o_wbr, o_mdr, o_hit, o_frc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Owns the single register-file write port.
- Arbitrates between the in-order writeback stage and a long-latency unit (mul/div result return). Writeback is the normal winner; the long-latency results wait in a small in-order FIFO with an anti-starvation counter.
- Produces the registered rf write triple consumed by the regfile, plus a pending-write query used by decode for hazard stalls.

Parameters:
- XLEN, 64, data width.
- AW, 5, register address width.
- FIFO_DEPTH, 2, long-latency holding entries (power of two, >=2).
- STARVE_MAX, 4, consecutive writeback grants allowed while the FIFO is non-empty before the FIFO head is forced.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- wb_valid  in  1  writeback stage has a write
- wb_waddr  in  AW  writeback destination
- wb_wdata  in  XLEN  writeback data
- wb_ready  out  1  write accepted this cycle; low stalls writeback
- mdu_valid  in  1  long-latency result available
- mdu_waddr  in  AW  long-latency destination
- mdu_wdata  in  XLEN  long-latency data
- mdu_ready  out  1  FIFO can accept
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  AW  regfile write address (registered)
- rf_wdata  out  XLEN  regfile write data (registered)
- qry_addr  in  AW  decode source register to check
- qry_hit  out  1  qry_addr has a write pending in the FIFO or in the output register
- starve_force  out  1  debug: FIFO head forced this cycle

Behaviour:
- Reset:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, starve_cnt=0.
  - wb_ready=0 and mdu_ready=0 while rst is high. qry_hit=0.
- Enqueue:
  - Occurs when mdu_valid && mdu_ready.
  - mdu_ready = !full, independent of mdu_valid and of same-cycle dequeue.
  - An enqueued entry is eligible for grant no earlier than the next cycle; there is no bypass.
- Grant, evaluated combinationally every cycle:
  - force = !empty && starve_cnt==STARVE_MAX.
  - If force: grant the FIFO head; wb_ready=0.
  - Else if wb_valid: grant writeback; wb_ready=1.
  - Else if !empty: grant the FIFO head.
  - Else: no grant.
  - wb_ready = !force. wb_ready never depends on wb_valid, so there is no combinational loop.
- Output stage, at the next posedge:
  - rf_we <= grant && (granted addr != 0).
  - rf_waddr / rf_wdata <= the granted pair; hold their last values when there is no grant.
  - Latency from grant to rf_we is 1 cycle; from mdu enqueue to rf_we is at least 2 cycles.
- x0:
  - A grant to address 0 completes its handshake and pops the FIFO if applicable.
  - rf_we stays 0.
- starve_cnt:
  - 0 when the FIFO is empty or a FIFO pop occurs.
  - Otherwise +1 on each writeback grant while non-empty.
  - Saturates at STARVE_MAX.
- FIFO order: strict in-order pops.
- Simultaneous enqueue and pop are legal when not full; the count is unchanged.
- Full and pop in the same cycle: mdu_ready is still 0 that cycle.
- qry_hit (combinational): true when qry_addr!=0 and it matches any valid FIFO entry, or matches rf_waddr with rf_we=1.
- WAW ordering between writeback and long-latency writes to the same register is not resolved here; decode's scoreboard guarantees it never occurs.
- Reset mid-operation: FIFO contents are discarded, counters are cleared, and no rf_we is issued in the cycle after reset.
- Pointer wrap: the pointers carry AW_F+1 bits (AW_F = log2 FIFO_DEPTH).
  - full = MSBs differ and the low bits are equal.
  - empty = pointers equal.

Decomposition:
- Shared defines header: XLEN/AW widths, and the RF write bus width and packing order {we, waddr, wdata}, matching the existing writeback bus.
- One natural sub-module: rf_wport_fifo (parameterised sync FIFO, registered storage, count/full/empty). Its entries are also exposed for qry_hit.
- Grant logic and starve counter live in the top module.

Test Plan:
- Writeback only: wb_valid=1 for 4 cycles to x1..x4 with data 0x11..0x44 -> rf_we=1 on cycles 1..4 with matching addr/data; wb_ready=1 throughout.
- MDU idle path: mdu pushes x5=0xDEAD at cycle 0 with wb_valid=0 -> FIFO granted at cycle 1, rf_we=1/x5/0xDEAD at cycle 2; qry_addr=5 gives qry_hit=1 on cycles 1 and 2.
- Starvation: FIFO holds x6 with wb_valid=1 continuously, STARVE_MAX=4 -> 4 writeback grants, then starve_force=1 and wb_ready=0 for one cycle, x6 written, after which wb_ready=1.
- Full: push 2 entries while wb_valid=1 -> mdu_ready=0; a third mdu_valid is held until a pop, then accepted; write order is preserved.
- x0: wb write to x0 with data 0xFF -> wb_ready=1, rf_we=0; an MDU x0 entry pops without a write.
- Reset: assert rst with the FIFO holding 2 entries -> the next cycles show rf_we=0, mdu_ready=0, qry_hit=0; after release mdu_ready=1 and the FIFO is empty.
